// File: rtl/led_pattern_seq_if.sv
// ---- led_pattern_seq_if : pattern-load handshake bundle (host -> sequencer) ----
// ---- Rev 1.0 ----
`default_nettype none

interface led_pattern_seq_if #(
  parameter int PAT_W = 8,
  parameter int DIV_W = 16
);
  logic             pat_valid;
  logic             pat_ready;
  logic [PAT_W-1:0] pat_data;
  logic [DIV_W-1:0] pat_div;
  logic [3:0]       pat_rpt;

  modport master (
    output pat_valid,
    output pat_data,
    output pat_div,
    output pat_rpt,
    input  pat_ready
  );

  modport slave (
    input  pat_valid,
    input  pat_data,
    input  pat_div,
    input  pat_rpt,
    output pat_ready
  );
endinterface

`default_nettype wire

// File: rtl/led_pattern_seq.sv
// ---- led_pattern_seq : LSB-first LED blink-pattern sequencer with repeat/loop ----
// ---- Rev 1.0 ----
`default_nettype none

module led_pattern_seq #(
  parameter int PAT_W = 8,
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  led_pattern_seq_if.slave pat,
  input  logic             stop,
  output logic             light,
  output logic             busy,
  output logic             done
);

  localparam int               IDX_W    = $clog2(PAT_W);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAT_W - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    PLAY = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [PAT_W-1:0]   pat_q, pat_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [DIV_W-1:0]   cnt_q, cnt_d;
  logic [3:0]         rpt_q, rpt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               light_q, light_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               step;
  logic               pat_end;
  logic               ready;
  logic               hs;

  assign step    = (cnt_q == div_q);
  assign pat_end = step && (idx_q == LAST_IDX);

  // In PLAY a new pattern is only taken at the loop boundary of a looping play
  always_comb begin
    ready = 1'b0;
    if (rst_n && !stop) begin
      case (state_q)
        IDLE:    ready = 1'b1;
        PLAY:    ready = (rpt_q == 4'd0) && pat_end;
        default: ready = 1'b0;
      endcase
    end
  end

  assign hs            = pat.pat_valid && ready;
  assign pat.pat_ready = ready;

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    rpt_d   = rpt_q;
    idx_d   = idx_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (hs) begin
          state_d = PLAY;
          pat_d   = pat.pat_data;
          div_d   = pat.pat_div;
          rpt_d   = pat.pat_rpt;
          idx_d   = '0;
          cnt_d   = '0;
        end
      end

      PLAY: begin
        if (stop) begin
          state_d = IDLE;
          cnt_d   = '0;
          idx_d   = '0;
        end else if (step) begin
          cnt_d = '0;
          if (idx_q == LAST_IDX) begin
            idx_d = '0;
            if (rpt_q == 4'd1) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end else if (rpt_q == 4'd0) begin
              if (hs) begin
                pat_d = pat.pat_data;
                div_d = pat.pat_div;
                rpt_d = pat.pat_rpt;
              end
            end else begin
              rpt_d = rpt_q - 4'd1;
            end
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Registered outputs reflect the bit that will be active next cycle
    busy_d  = (state_d == PLAY);
    light_d = busy_d && pat_d[idx_d];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pat_q   <= '0;
      div_q   <= '0;
      cnt_q   <= '0;
      rpt_q   <= '0;
      idx_q   <= '0;
      light_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      rpt_q   <= rpt_d;
      idx_q   <= idx_d;
      light_q <= light_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign light = light_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

`default_nettype wire

// File: tb/tb_led_pattern_seq.sv
// ---- tb_led_pattern_seq : directed self-checking bench for led_pattern_seq ----
// ---- Rev 1.0 ----
`default_nettype none

module tb_led_pattern_seq;

  localparam int PAT_W = 8;
  localparam int DIV_W = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic stop  = 1'b0;
  logic light;
  logic busy;
  logic done;

  int errors = 0;
  int checks = 0;

  led_pattern_seq_if #(.PAT_W(PAT_W), .DIV_W(DIV_W)) bus ();

  led_pattern_seq #(.PAT_W(PAT_W), .DIV_W(DIV_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .pat   (bus.slave),
    .stop  (stop),
    .light (light),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic outs(input string tag, input logic l, input logic b, input logic d);
    chk({tag, ".light"}, {31'd0, light}, {31'd0, l});
    chk({tag, ".busy"},  {31'd0, busy},  {31'd0, b});
    chk({tag, ".done"},  {31'd0, done},  {31'd0, d});
  endtask

  task automatic rdy(input string tag, input logic r);
    chk({tag, ".ready"}, {31'd0, bus.pat_ready}, {31'd0, r});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [7:0] d, input logic [15:0] dv, input logic [3:0] r);
    bus.pat_valid = 1'b1;
    bus.pat_data  = d;
    bus.pat_div   = dv;
    bus.pat_rpt   = r;
  endtask

  initial begin
    logic [15:0] exp_l;
    int          hold;

    // Reset held with a pattern on offer
    offer(8'hA3, 16'd1, 4'd1);
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(); #1;
      rdy("reset", 1'b0);
      outs("reset", 1'b0, 1'b0, 1'b0);
    end
    rst_n = 1'b1;
    #1;
    rdy("release", 1'b1);

    // Single play of A3 at div=1
    tick();
    bus.pat_valid = 1'b0;
    exp_l = 16'hCC0F;
    for (int i = 0; i < 16; i++) begin
      #1;
      outs("single", exp_l[i], 1'b1, 1'b0);
      tick();
    end
    #1;
    outs("single_done", 1'b0, 1'b0, 1'b1);
    rdy("single_done", 1'b1);
    tick(); #1;
    outs("single_after", 1'b0, 1'b0, 1'b0);

    // Repeat x3 of 01 at div=0
    offer(8'h01, 16'd0, 4'd3);
    tick();
    bus.pat_valid = 1'b0;
    for (int i = 0; i < 24; i++) begin
      #1;
      outs("repeat", (i % 8) == 0, 1'b1, 1'b0);
      tick();
    end
    #1;
    outs("repeat_done", 1'b0, 1'b0, 1'b1);

    // Back-to-back offer during the done cycle: looping FF
    offer(8'hFF, 16'd0, 4'd0);
    #1;
    rdy("b2b", 1'b1);
    tick();
    offer(8'h00, 16'd0, 4'd0);
    #1;
    outs("b2b_first", 1'b1, 1'b1, 1'b0);

    // Loop with replacement held on offer
    for (int i = 0; i < 16; i++) begin
      #1;
      rdy("loop", (i % 8) == 7);
      outs("loop", i < 8, 1'b1, 1'b0);
      tick();
    end

    // Stop in PLAY
    bus.pat_valid = 1'b0;
    stop = 1'b1;
    #1;
    rdy("loop_stop", 1'b0);
    tick(); #1;
    outs("loop_stop", 1'b0, 1'b0, 1'b0);

    // Stop in IDLE blocks accepts
    offer(8'h08, 16'd4, 4'd1);
    #1;
    rdy("idle_stop", 1'b0);
    tick(); #1;
    outs("idle_stop", 1'b0, 1'b0, 1'b0);
    stop = 1'b0;
    #1;
    rdy("idle_unstop", 1'b1);
    tick();
    bus.pat_valid = 1'b0;
    for (int i = 0; i < 15; i++) begin
      #1;
      outs("div4", 1'b0, 1'b1, 1'b0);
      tick();
    end
    #1;
    outs("div4_step3", 1'b1, 1'b1, 1'b0);
    stop = 1'b1;
    tick(); #1;
    outs("step3_stop", 1'b0, 1'b0, 1'b0);
    stop = 1'b0;
    tick(); #1;
    outs("step3_after", 1'b0, 1'b0, 1'b0);

    // Reset in the middle of a play
    offer(8'hFF, 16'd0, 4'd0);
    tick();
    bus.pat_valid = 1'b0;
    tick(); tick(); #1;
    outs("midrst_pre", 1'b1, 1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    rdy("midrst", 1'b0);
    tick(); #1;
    outs("midrst", 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    tick();

    // Maximum step period
    offer(8'h01, 16'hFFFF, 4'd1);
    tick();
    bus.pat_valid = 1'b0;
    hold = 0;
    while (light && busy && hold < 70000) begin
      hold++;
      tick();
    end
    chk("maxdiv_hold", 32'(hold), 32'd65536);
    #1;
    outs("maxdiv_bit1", 1'b0, 1'b1, 1'b0);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    #1;
    outs("maxdiv_stop", 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/led_pattern_seq.md
# led_pattern_seq

Programmable LED blink-pattern sequencer that sits directly upstream of the board's `light` pin driver and replaces the fixed divide-and-toggle blinker. A host loads a pattern word, a step period and a repeat count over a valid/ready handshake. The block shifts the pattern out LSB-first on `light`, holding each bit for a programmable number of clock cycles, then repeats it or loops it. It returns to idle with a one-cycle `done` pulse.

## Interface
- `PAT_W`, default 8: pattern length in bits/steps, minimum 2.
- `DIV_W`, default 16: width of the step-period field.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `pat_valid`  in  1  host offers a pattern.
- `pat_ready`  out  1  block accepts the offered pattern this cycle.
- `pat_data`  in  PAT_W  pattern; bit 0 is played first.
- `pat_div`  in  DIV_W  step period minus one; each bit is held `pat_div+1` cycles.
- `pat_rpt`  in  4  number of plays, 1–15; 0 means loop until replaced or stopped.
- `stop`  in  1  abort playback.
- `light`  out  1  LED drive; registered.
- `busy`  out  1  high while playing; registered.
- `done`  out  1  one-cycle pulse on normal completion; registered.

## Operation
- The block has two states, IDLE and PLAY. It holds latched copies `pat_q`, `div_q` and `rpt_q`, a step index `idx` (0..PAT_W-1) and a prescaler `cnt` (0..div_q).
- **Accept.** A handshake occurs when `pat_valid && pat_ready` at a rising edge. On a handshake the block latches `pat_data`, `pat_div` and `pat_rpt`, clears `idx` and `cnt`, and enters PLAY.
- **`pat_ready` is combinational:**
  - In IDLE: `rst_n && !stop`.
  - In PLAY with `rpt_q==0`: 1 only in the loop-boundary cycle (`cnt==div_q && idx==PAT_W-1 && !stop`).
  - Otherwise 0.
- **IDLE:** `light=0`, `busy=0`.
- **PLAY:** `light=pat_q[idx]` (registered), `busy=1`. `cnt` increments each cycle. When `cnt==div_q` a step occurs: `cnt<=0` and `idx<=idx+1`.
- **Pattern end** is a step with `idx==PAT_W-1`:
  - `rpt_q==1`: go to IDLE, `done<=1`.
  - `rpt_q` in 2..15: decrement `rpt_q`, set `idx<=0`.
  - `rpt_q==0` with a handshake in the same cycle: load the new pattern, `idx<=0`. This is seamless, with no gap cycle.
  - `rpt_q==0` without a handshake: set `idx<=0` and replay the same pattern.
- **`stop`:** in PLAY, next cycle is IDLE with `light=0` and `busy=0`; `done` is not pulsed. `stop` has priority over step, completion and handshake. In IDLE, `stop` only blocks accepts.
- **`pat_div=0`:** each bit lasts one cycle.
- **`pat_div` at maximum (2^DIV_W−1):** `cnt` must not overflow; the compare is on DIV_W bits.
- **Arithmetic:** `cnt` and `div_q` are DIV_W bits. `idx` is `$clog2(PAT_W)` bits. `rpt_q` is 4 bits and never decrements below 1.
- **Stable inputs:** inputs change only after `clk` edges. Inputs other than `pat_valid` are ignored when no handshake occurs.

## Timing
- **Reset:** while `rst_n=0`, at each edge the block sets state=IDLE, `light=0`, `busy=0`, `done=0`, and `cnt`, `idx`, `rpt_q`, `pat_q`, `div_q` all to 0. `pat_ready=0` combinationally while `rst_n=0`.
- **Reset mid-PLAY:** aborts immediately at the next edge; no `done`.
- **Accept to first bit:** handshake at edge T → `light=pat_data[0]` and `busy=1` from T+1. Latency is one cycle.
- **Play duration:** a full play lasts `rpt*PAT_W*(pat_div+1)` cycles with `busy=1`.
- **Completion:** the last step edge is E.
  - `busy=0`, `light=0` and `done=1` in cycle E+1 only.
  - `pat_ready=1` in cycle E+1, so a new pattern may be accepted while `done=1`. Its first bit appears at E+2.
- **Loop replacement:** a pattern accepted at boundary edge B drives its bit 0 from B+1.

## Test plan
- **Reset:** hold `rst_n=0` for 3 cycles with `pat_valid=1` → `pat_ready=0`, `light=0`, `busy=0`, `done=0`, no accept. After release, accept at the first edge.
- **Single play:** PAT_W=8, `pat_data=8'b1010_0011`, `pat_div=1`, `pat_rpt=1` → `light`=1,1,1,1,0,0,0,0,0,0,1,1,0,0,1,1 from T+1. `busy` is high for 16 cycles, then `done=1` for exactly one cycle with `light=0`.
- **Repeat:** `pat_data=8'h01`, `pat_div=0`, `pat_rpt=3` → `light` high at T+1, T+9 and T+17 only. `busy` is high for 24 cycles and `done` pulses at T+25. A back-to-back pattern offered during the `done` cycle is accepted.
- **Loop and replace:** `pat_data=8'hFF`, `pat_rpt=0`, `pat_div=0`, then `pat_valid=1` with `8'h00` held → `pat_ready` is high only in the idx=7 cycles. `light` goes from 1 to 0 exactly at the boundary+1, with no gap and no `done`.
- **Stop:** assert `stop` at step 3 of a `pat_div=4` play → IDLE next cycle, `light=0`, `busy=0`, no `done`. `stop` with `pat_valid` in IDLE → `pat_ready=0`, no accept.
- **Mid-play reset and max period:** `rst_n=0` mid-play → all outputs are 0 next cycle. `pat_div=16'hFFFF` → bit 0 is held exactly 65536 cycles.
